// File: rtl/queue_arb.sv
`default_nettype none
// ============================================================================
// Module   : queue_arb
// Purpose  : Three-way round-robin arbiter (two writers, one reader) in front
//            of an external queue. One queue operation is in flight at a time;
//            each operation takes IDLE -> WR/RD -> GAP, i.e. three cycles.
//            Occupancy is tracked locally and checked against the queue's
//            non-empty flag.
// Ports    : CLK, RST          clock, synchronous active-high reset
//            REQ0/REQ1, DI0/DI1 write requests and their data
//            ACK0/ACK1          one-cycle write-complete pulses
//            RDREQ, RDACK, RDO  read request, read-complete pulse, read word
//            QPUS/QPOP, QDI     push/pop strobes and write data to the queue
//            QDO, QDF           queue head word and non-empty flag
//            CNT, FULL, EMPTY   occupancy and derived flags
//            ERR                sticky occupancy/queue-flag mismatch
// Revision : 1.0  initial release
// ============================================================================
module queue_arb #(
  parameter int BITSIZE = 8,
  parameter int ADDSIZE = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ0,
  input  logic               REQ1,
  input  logic [BITSIZE-1:0] DI0,
  input  logic [BITSIZE-1:0] DI1,
  output logic               ACK0,
  output logic               ACK1,
  input  logic               RDREQ,
  output logic               RDACK,
  output logic [BITSIZE-1:0] RDO,
  output logic               QPUS,
  output logic               QPOP,
  output logic [BITSIZE-1:0] QDI,
  input  logic [BITSIZE-1:0] QDO,
  input  logic               QDF,
  output logic [ADDSIZE-1:0] CNT,
  output logic               FULL,
  output logic               EMPTY,
  output logic               ERR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // Source encoding for the round-robin pointer and the grant record.
  localparam logic [1:0] C_SRC_R0 = 2'd0;
  localparam logic [1:0] C_SRC_R1 = 2'd1;
  localparam logic [1:0] C_SRC_RD = 2'd2;

  localparam logic [ADDSIZE-1:0] C_MAX = '1;
  localparam logic [ADDSIZE-1:0] C_ONE = {{(ADDSIZE-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_last;     // last granted source
  logic [1:0]         r_gsrc;     // source owning the operation in flight
  logic [BITSIZE-1:0] r_qdi;
  logic [BITSIZE-1:0] r_rdo;
  logic [ADDSIZE-1:0] r_cnt;
  logic [ADDSIZE-1:0] w_cnt_nxt;
  logic               r_full;
  logic               r_empty;
  logic               r_err;

  logic [3:0]         w_elig;     // bit 3 is a constant-zero pad for 2-bit indexing
  logic [1:0]         w_o0;
  logic [1:0]         w_o1;
  logic [1:0]         w_o2;
  logic               w_grant;
  logic [1:0]         w_gsel;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_gsel      = C_SRC_R0;
    w_o0        = C_SRC_R0;
    w_o1        = C_SRC_R1;
    w_o2        = C_SRC_RD;
    w_elig      = {1'b0, RDREQ & ~r_empty, REQ1 & ~r_full, REQ0 & ~r_full};

    // Search order starts at the source after the last granted one.
    case (r_last)
      C_SRC_R0: begin w_o0 = C_SRC_R1; w_o1 = C_SRC_RD; w_o2 = C_SRC_R0; end
      C_SRC_R1: begin w_o0 = C_SRC_RD; w_o1 = C_SRC_R0; w_o2 = C_SRC_R1; end
      default:  begin w_o0 = C_SRC_R0; w_o1 = C_SRC_R1; w_o2 = C_SRC_RD; end
    endcase

    if (w_elig[w_o0]) begin
      w_grant = 1'b1;
      w_gsel  = w_o0;
    end else if (w_elig[w_o1]) begin
      w_grant = 1'b1;
      w_gsel  = w_o1;
    end else if (w_elig[w_o2]) begin
      w_grant = 1'b1;
      w_gsel  = w_o2;
    end

    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = (w_gsel == C_SRC_RD) ? S_RD : S_WR;
        end
      end
      S_WR: begin
        w_state_nxt = S_GAP;
        if (r_cnt != C_MAX) begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      S_RD: begin
        w_state_nxt = S_GAP;
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_last  <= C_SRC_RD;      // so R0 is searched first
      r_gsrc  <= C_SRC_R0;
      r_qdi   <= '0;
      r_rdo   <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == C_MAX);
      r_empty <= (w_cnt_nxt == '0);

      if (r_state == S_IDLE && w_grant) begin
        r_last <= w_gsel;
        r_gsrc <= w_gsel;
        case (w_gsel)
          C_SRC_R0: r_qdi <= DI0;
          C_SRC_R1: r_qdi <= DI1;
          default:  r_rdo <= QDO;  // head captured before the pop strobe
        endcase
      end

      // Queue flag is only trusted between operations.
      if (r_state == S_IDLE && (QDF != (r_cnt != '0))) begin
        r_err <= 1'b1;
      end
    end
  end

  // Strobes and acks decode straight from the state register, so a reset
  // edge drops them immediately and an aborted operation never acks.
  assign QPUS  = (r_state == S_WR);
  assign QPOP  = (r_state == S_RD);
  assign ACK0  = (r_state == S_GAP) && (r_gsrc == C_SRC_R0);
  assign ACK1  = (r_state == S_GAP) && (r_gsrc == C_SRC_R1);
  assign RDACK = (r_state == S_GAP) && (r_gsrc == C_SRC_RD);
  assign QDI   = r_qdi;
  assign RDO   = r_rdo;
  assign CNT   = r_cnt;
  assign FULL  = r_full;
  assign EMPTY = r_empty;
  assign ERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_queue_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_arb
// Purpose  : Self-checking bench for queue_arb with a behavioural queue
//            attached (ADDSIZE=3, capacity 7).
// Revision : 1.0  initial release
// ============================================================================
module tb_queue_arb;

  localparam int BW = 8;
  localparam int AW = 3;
  localparam int CAP = 7;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ0 = 1'b0, REQ1 = 1'b0, RDREQ = 1'b0;
  logic [BW-1:0] DI0 = '0, DI1 = '0;
  logic          ACK0, ACK1, RDACK, QPUS, QPOP, FULL, EMPTY, ERR, QDF;
  logic [BW-1:0] RDO, QDI, QDO;
  logic [AW-1:0] CNT;

  int checks = 0;
  int errors = 0;

  queue_arb #(.BITSIZE(BW), .ADDSIZE(AW)) dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .DI0(DI0), .DI1(DI1),
    .ACK0(ACK0), .ACK1(ACK1), .RDREQ(RDREQ), .RDACK(RDACK), .RDO(RDO),
    .QPUS(QPUS), .QPOP(QPOP), .QDI(QDI), .QDO(QDO), .QDF(QDF),
    .CNT(CNT), .FULL(FULL), .EMPTY(EMPTY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Attached queue: acts on rising strobes, cleared together with the arbiter.
  logic [BW-1:0] qm[$];
  logic          pq = 1'b0, pp = 1'b0;
  logic [BW-1:0] qdo_m = '0;
  logic          qdf_m = 1'b0;
  logic          qdf_force = 1'b0;

  always @(posedge CLK) begin
    if (RST) qm.delete();
    #1;
    if (QPUS && !pq) qm.push_back(QDI);
    if (QPOP && !pp && qm.size() > 0) void'(qm.pop_front());
    pq    <= QPUS;
    pp    <= QPOP;
    qdo_m <= (qm.size() > 0) ? qm[0] : '0;
    qdf_m <= (qm.size() > 0);
  end

  assign QDO = qdo_m;
  assign QDF = qdf_m | qdf_force;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; RDREQ = 1'b0; qdf_force = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Raise a write request, wait (bounded) for its ack, then drop it.
  task automatic do_write(input int s, input logic [BW-1:0] d);
    int n;
    logic got;
    n = 0; got = 1'b0;
    if (s == 0) begin REQ0 = 1'b1; DI0 = d; end
    else        begin REQ1 = 1'b1; DI1 = d; end
    while (!got && n < 20) begin
      @(negedge CLK);
      n++;
      got = (s == 0) ? ACK0 : ACK1;
    end
    chk("write_ack", got, 1);
    if (s == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
  endtask

  // Round-robin winner from the rule: first eligible after the last grant.
  function automatic int rr_pick(input int last, input logic [2:0] el);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (el[idx]) return idx;
    end
    return 3;
  endfunction

  typedef struct packed {
    logic          rst, r0, r1, rd;
    logic [BW-1:0] d0, d1;
    logic [4:0]    strb;   // {QPUS, QPOP, ACK0, ACK1, RDACK}
    logic [AW-1:0] cnt;
    logic          emp;
    logic [BW-1:0] qdi, rdo;
  } vec_t;

  function automatic vec_t mk(input logic rst, r0, r1, rd, input logic [BW-1:0] d0, d1,
                              input logic [4:0] strb, input logic [AW-1:0] cnt,
                              input logic emp, input logic [BW-1:0] qdi, rdo);
    vec_t v;
    v = '{rst, r0, r1, rd, d0, d1, strb, cnt, emp, qdi, rdo};
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    int acks [$];
    int exp31 [4];
    int n;
    logic seen;
    // random-phase state
    logic [BW-1:0] ref_q [$];
    logic [BW-1:0] wdata [2];
    logic [2:0]    pend, e1, e2, el, a;
    int            wait_cnt [3];
    int            last_ref, src, exp_src;
    logic          prev_pus, prev_pop, bad;
    logic [31:0]   exp_rd;

    // Cycle-by-cycle sequences: single write, then 0x11/0x22 written and read back.
    tbl[0]  = mk(0,1,0,0,8'hA5,8'h00,5'b10000,3'd0,1,8'hA5,8'h00);
    tbl[1]  = mk(0,1,0,0,8'hA5,8'h00,5'b00100,3'd1,0,8'hA5,8'h00);
    tbl[2]  = mk(0,0,0,0,8'h00,8'h00,5'b00000,3'd1,0,8'hA5,8'h00);
    tbl[3]  = mk(1,0,0,0,8'h00,8'h00,5'b00000,3'd0,1,8'h00,8'h00);
    tbl[4]  = mk(0,1,0,0,8'h11,8'h00,5'b10000,3'd0,1,8'h11,8'h00);
    tbl[5]  = mk(0,1,0,0,8'h11,8'h00,5'b00100,3'd1,0,8'h11,8'h00);
    tbl[6]  = mk(0,0,1,0,8'h00,8'h22,5'b00000,3'd1,0,8'h11,8'h00);
    tbl[7]  = mk(0,0,1,0,8'h00,8'h22,5'b10000,3'd1,0,8'h22,8'h00);
    tbl[8]  = mk(0,0,1,0,8'h00,8'h22,5'b00010,3'd2,0,8'h22,8'h00);
    tbl[9]  = mk(0,0,0,1,8'h00,8'h00,5'b00000,3'd2,0,8'h22,8'h00);
    tbl[10] = mk(0,0,0,1,8'h00,8'h00,5'b01000,3'd2,0,8'h22,8'h11);
    tbl[11] = mk(0,0,0,1,8'h00,8'h00,5'b00001,3'd1,0,8'h22,8'h11);
    tbl[12] = mk(0,0,0,0,8'h00,8'h00,5'b00000,3'd1,0,8'h22,8'h11);
    tbl[13] = mk(0,0,0,1,8'h00,8'h00,5'b01000,3'd1,0,8'h22,8'h22);
    tbl[14] = mk(0,0,0,1,8'h00,8'h00,5'b00001,3'd0,1,8'h22,8'h22);
    tbl[15] = mk(0,0,0,0,8'h00,8'h00,5'b00000,3'd0,1,8'h22,8'h22);
    tbl[16] = mk(0,0,0,1,8'h00,8'h00,5'b00000,3'd0,1,8'h22,8'h22);
    tbl[17] = mk(0,0,0,1,8'h00,8'h00,5'b00000,3'd0,1,8'h22,8'h22);
    tbl[18] = mk(0,0,0,0,8'h00,8'h00,5'b00000,3'd0,1,8'h22,8'h22);

    // ---- reset state ----
    do_reset();
    chk("reset_strobes", {QPUS, QPOP, ACK0, ACK1, RDACK}, 0);
    chk("reset_flags", {ERR, FULL, EMPTY}, 3'b001);
    chk("reset_data", {CNT, RDO, QDI}, 0);

    // ---- table-driven vectors ----
    for (int i = 0; i < 19; i++) begin
      RST = tbl[i].rst; REQ0 = tbl[i].r0; REQ1 = tbl[i].r1; RDREQ = tbl[i].rd;
      DI0 = tbl[i].d0;  DI1 = tbl[i].d1;
      @(negedge CLK);
      chk($sformatf("vec%0d", i),
          {QPUS, QPOP, ACK0, ACK1, RDACK, CNT, EMPTY, QDI, RDO},
          {tbl[i].strb, tbl[i].cnt, tbl[i].emp, tbl[i].qdi, tbl[i].rdo});
    end
    RST = 1'b0;
    chk("vec_err", ERR, 0);

    // ---- both writers held: grants alternate, acks 3 cycles apart ----
    do_reset();
    REQ0 = 1'b1; REQ1 = 1'b1; DI0 = 8'h31; DI1 = 8'h32;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      if (ACK0) acks.push_back(c);
      if (ACK1) acks.push_back(100 + c);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    exp31 = '{2, 105, 8, 111};
    chk("alt_ack_count", acks.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("alt_ack%0d", k), (k < acks.size()) ? acks[k] : -1, exp31[k]);
    chk("alt_cnt", CNT, 4);

    // ---- fill to full, blocked write, read frees a slot ----
    do_reset();
    for (int k = 0; k < CAP; k++) do_write(0, 8'h40 + k[7:0]);
    @(negedge CLK);
    chk("full_flags", {FULL, EMPTY, CNT}, {1'b1, 1'b0, 3'd7});
    REQ0 = 1'b1; DI0 = 8'h99;
    seen = 1'b0;
    repeat (6) begin @(negedge CLK); seen |= ACK0 | QPUS; end
    chk("full_blocks_write", seen, 0);
    RDREQ = 1'b1;
    n = 0; seen = 1'b0;
    while (!RDACK && n < 10) begin @(negedge CLK); n++; seen |= ACK0; end
    chk("full_read_ack", {RDACK, seen}, 2'b10);
    chk("full_read_data", RDO, 8'h40);
    chk("full_after_read", FULL, 0);
    RDREQ = 1'b0;
    n = 0;
    while (!ACK0 && n < 10) begin @(negedge CLK); n++; end
    chk("pending_write_served", ACK0, 1);
    REQ0 = 1'b0;
    chk("refilled", {FULL, CNT}, {1'b1, 3'd7});

    // ---- reset during WR aborts the write ----
    do_reset();
    REQ0 = 1'b1; DI0 = 8'h5A;
    n = 0;
    do begin @(negedge CLK); n++; end while (!QPUS && n < 5);
    chk("abort_in_wr", QPUS, 1);
    RST = 1'b1; REQ0 = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_reset", {QPUS, ACK0, CNT}, 0);
    @(negedge CLK);
    chk("abort_after", {QPUS, ACK0, ERR, CNT}, 0);

    // ---- requester dropping before its grant leaves no trace ----
    do_reset();
    REQ0 = 1'b1; DI0 = 8'h61; REQ1 = 1'b1; DI1 = 8'h62;
    @(negedge CLK);
    REQ1 = 1'b0;
    n = 0; seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (ACK0) begin n++; REQ0 = 1'b0; end
      seen |= ACK1;
    end
    chk("drop_no_ack1", seen, 0);
    chk("drop_one_ack0", n, 1);
    chk("drop_cnt", CNT, 1);

    // ---- ERR: flag mismatch in IDLE is sticky until reset ----
    do_reset();
    qdf_force = 1'b1;
    @(negedge CLK);
    qdf_force = 1'b0;
    chk("err_set", ERR, 1);
    repeat (5) @(negedge CLK);
    chk("err_sticky", ERR, 1);
    do_reset();
    chk("err_cleared", ERR, 0);

    // ---- randomized traffic against a transaction-level reference ----
    do_reset();
    ref_q.delete();
    pend = '0; e1 = '0; e2 = '0; last_ref = 2;
    prev_pus = 1'b0; prev_pop = 1'b0;
    wdata[0] = '0; wdata[1] = '0;
    for (int s = 0; s < 3; s++) wait_cnt[s] = 0;
    for (int t = 0; t < 1800; t++) begin
      @(negedge CLK);
      a = {RDACK, ACK1, ACK0};
      bad = (QPUS && QPOP) || (QPUS && prev_pus) || (QPOP && prev_pop) || ($countones(a) > 1);
      chk("rnd_protocol", bad, 0);
      prev_pus = QPUS; prev_pop = QPOP;
      if (a != 3'b000) begin
        src = a[0] ? 0 : (a[1] ? 1 : 2);
        exp_src = rr_pick(last_ref, e2);
        chk("rnd_grant", src, exp_src);
        last_ref = src;
        if (src < 2) ref_q.push_back(wdata[src]);
        else begin
          exp_rd = (ref_q.size() > 0) ? {24'h0, ref_q.pop_front()} : 32'hDEAD;
          chk("rnd_rdo", RDO, exp_rd);
        end
        pend[src] = 1'b0; wait_cnt[src] = 0;
      end
      chk("rnd_occupancy", {FULL, EMPTY, CNT},
          {ref_q.size() == CAP, ref_q.size() == 0, ref_q.size()[AW-1:0]});
      for (int s = 0; s < 3; s++) begin
        if (pend[s]) begin
          wait_cnt[s]++;
          if (wait_cnt[s] > 300) begin
            checks++; errors++;
            $display("FAIL rnd_timeout src=%0d waited=%0d limit=300", s, wait_cnt[s]);
            pend[s] = 1'b0; wait_cnt[s] = 0;
          end
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (!pend[s] && ((((t / 150) % 2) == 0) ? ($urandom % 2 == 0) : ($urandom % 8 == 0))) begin
          pend[s] = 1'b1;
          wdata[s] = BW'($urandom);
        end
      end
      if (!pend[2] && ((((t / 150) % 2) == 0) ? ($urandom % 8 == 0) : ($urandom % 2 == 0)))
        pend[2] = 1'b1;
      REQ0 = pend[0]; REQ1 = pend[1]; RDREQ = pend[2];
      DI0 = wdata[0]; DI1 = wdata[1];
      el = {pend[2] & ~EMPTY, pend[1] & ~FULL, pend[0] & ~FULL};
      e2 = e1; e1 = el;
    end
    REQ0 = 1'b0; REQ1 = 1'b0; RDREQ = 1'b0;
    chk("rnd_err", ERR, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
